// File: rtl/axis_packet_forwarder_pkg.sv
// Shared types and constants for the packet forwarder: FSM encoding and
// output FIFO geometry.
package axis_packet_forwarder_pkg;

  typedef enum logic [1:0] {
    FWD_IDLE = 2'd0,
    FWD_RUN  = 2'd1,
    FWD_DONE = 2'd2,
    FWD_GAP  = 2'd3
  } fwd_state_t;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/axis_packet_forwarder_fifo3.sv
// Three-entry shift FIFO. The head lives in entry 0, so it comes straight from
// a register. A push and a pop in the same cycle are legal even when full.
module axis_packet_forwarder_fifo3
  import axis_packet_forwarder_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      entry_reg  [FIFO_DEPTH];
  logic [WIDTH-1:0]      entry_next [FIFO_DEPTH];
  logic [FIFO_CNT_W-1:0] count_reg, count_next, wr_idx;
  logic                  do_pop, do_push;

  always_comb begin
    do_pop  = pop && (count_reg != '0);
    do_push = push && ((count_reg != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
    wr_idx  = do_pop ? count_reg - FIFO_CNT_W'(1) : count_reg;
    for (int i = 0; i < FIFO_DEPTH; i++) entry_next[i] = entry_reg[i];
    if (do_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) entry_next[i] = entry_reg[i+1];
    end
    if (do_push) entry_next[wr_idx] = push_data;
    count_next = count_reg;
    if (do_push && !do_pop) count_next = count_reg + FIFO_CNT_W'(1);
    else if (do_pop && !do_push) count_next = count_reg - FIFO_CNT_W'(1);
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_reg[gi] <= '0;
        else     entry_reg[gi] <= entry_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_reg <= '0;
    else     count_reg <= count_next;
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/axis_packet_forwarder.sv
// Streams one accepted packet out of packet memory as an AXI4-Stream master and
// pulses forwarder_done when the last beat has been taken downstream.
module axis_packet_forwarder
  import axis_packet_forwarder_pkg::*;
#(
  parameter  int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter  int DATA_WIDTH           = 64,
  localparam int PLEN_WIDTH           = SNOOP_FWD_ADDR_WIDTH + 1
) (
  input  logic                            axi_aclk,
  input  logic                            rst,
  input  logic                            ready_for_forwarder,
  input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                            forwarder_rd_en,
  input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
  output logic                            forwarder_done,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  localparam logic [PLEN_WIDTH-1:0] MAX_LEN = {1'b1, {SNOOP_FWD_ADDR_WIDTH{1'b0}}};
  localparam logic [PLEN_WIDTH-1:0] ONE     = PLEN_WIDTH'(1);

  fwd_state_t                      state_reg, state_next;
  logic [PLEN_WIDTH-1:0]           len_reg, issued_reg, ret_idx_reg;
  logic [SNOOP_FWD_ADDR_WIDTH-1:0] last_addr_reg;
  logic                            inflight_reg;
  logic                            issue, start, pop, ret_last;
  logic [FIFO_CNT_W-1:0]           fifo_count;
  logic [FIFO_CNT_W:0]             occupancy;
  logic [DATA_WIDTH:0]             head;

  // Read gating uses only registered occupancy, keeping tready off the rd_en path.
  always_comb begin
    state_next     = state_reg;
    start          = 1'b0;
    forwarder_done = 1'b0;
    occupancy      = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight_reg};
    issue          = (state_reg == FWD_RUN) && (issued_reg < len_reg) &&
                     (occupancy < (FIFO_CNT_W+1)'(FIFO_DEPTH));
    case (state_reg)
      FWD_IDLE: begin
        if (ready_for_forwarder) begin
          start      = 1'b1;
          state_next = FWD_RUN;
        end
      end
      FWD_RUN: begin
        if (len_reg == '0 || (pop && head[DATA_WIDTH])) state_next = FWD_DONE;
      end
      FWD_DONE: begin
        forwarder_done = 1'b1;
        state_next     = FWD_GAP;
      end
      default: state_next = FWD_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      state_reg     <= FWD_IDLE;
      len_reg       <= '0;
      issued_reg    <= '0;
      ret_idx_reg   <= '0;
      inflight_reg  <= 1'b0;
      last_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (start) begin
        len_reg     <= (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;
        issued_reg  <= '0;
        ret_idx_reg <= '0;
      end else begin
        if (issue)        issued_reg  <= issued_reg + ONE;
        if (inflight_reg) ret_idx_reg <= ret_idx_reg + ONE;
      end
      if (issue) last_addr_reg <= issued_reg[SNOOP_FWD_ADDR_WIDTH-1:0];
    end
  end

  assign ret_last          = (ret_idx_reg == len_reg - ONE);
  assign forwarder_rd_en   = issue;
  assign forwarder_rd_addr = issue ? issued_reg[SNOOP_FWD_ADDR_WIDTH-1:0] : last_addr_reg;

  axis_packet_forwarder_fifo3 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (axi_aclk),
    .rst      (rst),
    .push     (inflight_reg),
    .push_data({ret_last, forwarder_rd_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_WIDTH];
  assign pop           = m_axis_tvalid & m_axis_tready;

endmodule

// File: tb/tb_axis_packet_forwarder.sv
// Self-checking bench: a directed packet table plus randomized packets, scored
// against a memory model and a per-packet stream/latency reference.
module tb_axis_packet_forwarder;

  localparam int AW   = 9;
  localparam int DW   = 64;
  localparam int PW   = AW + 1;
  localparam int MAXL = 512;

  logic          axi_aclk = 1'b0;
  logic          rst;
  logic          ready_for_forwarder;
  logic [PW-1:0] len_to_forwarder;
  logic [AW-1:0] forwarder_rd_addr;
  logic          forwarder_rd_en;
  logic [DW-1:0] forwarder_rd_data;
  logic          forwarder_done;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  axis_packet_forwarder #(
    .SNOOP_FWD_ADDR_WIDTH(AW),
    .DATA_WIDTH          (DW)
  ) dut (
    .axi_aclk           (axi_aclk),
    .rst                (rst),
    .ready_for_forwarder(ready_for_forwarder),
    .len_to_forwarder   (len_to_forwarder),
    .forwarder_rd_addr  (forwarder_rd_addr),
    .forwarder_rd_en    (forwarder_rd_en),
    .forwarder_rd_data  (forwarder_rd_data),
    .forwarder_done     (forwarder_done),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready)
  );

  always #5 axi_aclk = ~axi_aclk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tready_mode = 0;
  int          pkt_seq = 0;
  logic [31:0] salt = 32'h0;
  int          idle_from = 0;

  // Per-packet reference state
  bit          pkt_active = 1'b0;
  int          cur_len, exp_addr, beat_idx, reads, accepted;
  int          first_rd, last_rd, first_v, last_beat, done_cyc, done_cnt;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_last;

  typedef struct {
    int len_in;
    int mode;      // 0: tready=1, 1: 1,0,0 pattern, 2: random
    int exp_len;
    bit b2b;       // keep ready high into the next vector
  } vec_t;
  vec_t vecs[10];

  function automatic logic [63:0] mem_word(input int seq, input logic [31:0] s, input int addr);
    logic [31:0] a;
    logic [31:0] q;
    a = addr;
    q = seq;
    return {s ^ (a * 32'h9E3779B1), q[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge axi_aclk);
    cyc++;
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Packet memory: read data appears exactly one cycle after rd_en.
  initial begin
    logic          rd_v;
    logic [DW-1:0] word;
    forwarder_rd_data = '0;
    forever begin
      @(negedge axi_aclk);
      rd_v = forwarder_rd_en && !rst;
      word = mem_word(pkt_seq, salt, int'(forwarder_rd_addr));
      @(posedge axi_aclk);
      #1;
      forwarder_rd_data = rd_v ? word : {$urandom, $urandom};
    end
  end

  initial forever begin
    @(negedge axi_aclk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!pkt_active) begin
        chk("idle_quiet", 64'({forwarder_rd_en, m_axis_tvalid, forwarder_done}), 64'd0);
      end else begin
        if (forwarder_rd_en) begin
          chk("rd_addr", 64'(forwarder_rd_addr), 64'(exp_addr));
          chk("rd_in_range", 64'(exp_addr < cur_len), 64'd1);
          chk("rd_occupancy", 64'((reads - accepted) < 3), 64'd1);
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          exp_addr++;
          reads++;
        end
        if (prev_stall) begin
          chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
          chk("hold_data", m_axis_tdata, prev_data);
          chk("hold_last", 64'(m_axis_tlast), 64'(prev_last));
        end
        if (m_axis_tvalid && first_v < 0) first_v = cyc;
        if (m_axis_tvalid && m_axis_tready) begin
          chk("beat_in_len", 64'(beat_idx < cur_len), 64'd1);
          chk("beat_data", m_axis_tdata, mem_word(pkt_seq, salt, beat_idx));
          chk("beat_last", 64'(m_axis_tlast), 64'(beat_idx == cur_len - 1));
          last_beat = cyc;
          beat_idx++;
          accepted++;
        end
        if (forwarder_done) begin
          if (done_cyc < 0) done_cyc = cyc;
          done_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Begins a packet; t is the cycle in which the DUT, sitting in IDLE, sees ready.
  task automatic start_pkt(input int len_in, input int mode, input int exp_len,
                           input bit ready_held, output int t);
    @(posedge axi_aclk);
    #1;
    pkt_seq++;
    salt       = $urandom;
    cur_len    = exp_len;
    exp_addr   = 0;
    beat_idx   = 0;
    reads      = 0;
    accepted   = 0;
    first_rd   = -1;
    last_rd    = -1;
    first_v    = -1;
    last_beat  = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    tready_mode = mode;
    pkt_active = 1'b1;
    if (ready_held) begin
      t = idle_from;
    end else begin
      ready_for_forwarder = 1'b1;
      len_to_forwarder    = PW'(len_in);
      t = (cyc > idle_from) ? cyc : idle_from;
    end
  endtask

  task automatic drop_ready(input int t, input bit hold, input int next_len);
    while (cyc < t + 1) begin
      @(posedge axi_aclk);
      #1;
    end
    ready_for_forwarder = hold;
    len_to_forwarder    = hold ? PW'(next_len) : PW'($urandom_range(0, 1023));
  endtask

  task automatic finish_pkt(input int t, input int len_in, input int exp_len, input int mode);
    int bound;
    bound = 8 * exp_len + 40;
    for (int i = 0; i < bound && done_cyc < 0; i++) begin
      @(posedge axi_aclk);
      #1;
    end
    @(posedge axi_aclk);
    #1;
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("beats", 64'(accepted), 64'(exp_len));
    chk("reads", 64'(reads), 64'(exp_len));
    chk("done_width", 64'(done_cnt), 64'd1);
    if (exp_len == 0) begin
      chk("zero_done_lat", 64'(done_cyc - t), 64'd2);
      chk("zero_no_valid", 64'(first_v < 0), 64'd1);
    end else begin
      chk("first_rd_lat", 64'(first_rd - t), 64'd1);
      chk("first_valid_lat", 64'(first_v - t), 64'd3);
      chk("done_after_last", 64'(done_cyc - last_beat), 64'd1);
      if (mode == 0) begin
        chk("last_rd_lat", 64'(last_rd - t), 64'(exp_len));
        chk("throughput", 64'(last_beat - t), 64'(exp_len + 2));
      end
    end
    $display("pkt %0d len_in=%0d len=%0d mode=%0d seen@%0d beats=%0d done@%0d",
             pkt_seq, len_in, exp_len, mode, t, accepted, done_cyc);
    idle_from  = (done_cyc >= 0) ? done_cyc + 2 : cyc;
    pkt_active = 1'b0;
  endtask

  task automatic run_pkt(input int len_in, input int mode, input int exp_len);
    int t;
    start_pkt(len_in, mode, exp_len, 1'b0, t);
    drop_ready(t, 1'b0, 0);
    finish_pkt(t, len_in, exp_len, mode);
  endtask

  initial begin
    int  t, nl, l, found;
    bit  held;

    vecs[0] = '{4,    0, 4,   1'b0};
    vecs[1] = '{6,    1, 6,   1'b0};
    vecs[2] = '{0,    0, 0,   1'b0};
    vecs[3] = '{512,  0, 512, 1'b0};
    vecs[4] = '{700,  0, 512, 1'b0};
    vecs[5] = '{5,    0, 5,   1'b1};
    vecs[6] = '{7,    0, 7,   1'b0};
    vecs[7] = '{0,    0, 0,   1'b1};
    vecs[8] = '{3,    1, 3,   1'b0};
    vecs[9] = '{1,    2, 1,   1'b0};

    rst                 = 1'b1;
    ready_for_forwarder = 1'b0;
    len_to_forwarder    = '0;
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_rd_en", 64'(forwarder_rd_en), 64'd0);
    chk("rst_done", 64'(forwarder_done), 64'd0);
    chk("rst_rd_addr", 64'(forwarder_rd_addr), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    repeat (3) @(posedge axi_aclk);
    #1;
    rst       = 1'b0;
    idle_from = cyc;

    for (int i = 0; i < 10; i++) begin
      held = (i > 0) && vecs[i-1].b2b;
      nl   = 0;
      if (vecs[i].b2b && i < 9) nl = vecs[i+1].len_in;
      start_pkt(vecs[i].len_in, vecs[i].mode, vecs[i].exp_len, held, t);
      drop_ready(t, vecs[i].b2b, nl);
      finish_pkt(t, vecs[i].len_in, vecs[i].exp_len, vecs[i].mode);
    end

    // Asynchronous reset in the middle of an 8-word packet.
    start_pkt(8, 1, 8, 1'b0, t);
    drop_ready(t, 1'b0, 0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(posedge axi_aclk);
      #1;
      if (beat_idx == 2 && m_axis_tvalid) found = 1;
    end
    chk("mid_rst_setup", 64'(found), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_rd_en", 64'(forwarder_rd_en), 64'd0);
    chk("mid_rst_done", 64'(forwarder_done), 64'd0);
    chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
    repeat (2) @(posedge axi_aclk);
    #1;
    rst        = 1'b0;
    pkt_active = 1'b0;
    idle_from  = cyc;
    repeat (3) @(posedge axi_aclk);
    run_pkt(3, 0, 3);

    // Randomized packets, lengths and downstream backpressure.
    for (int k = 0; k < 16; k++) begin
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(513, 1023))
                                      : int'($urandom_range(0, 24));
      repeat ($urandom_range(0, 3)) @(posedge axi_aclk);
      run_pkt(l, int'($urandom_range(0, 2)), (l > MAXL) ? MAXL : l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
